// File: rtl/decoder_n_scan_if.sv
// Control and decoded-output bundle for decoder_n_scan.
// The master side drives enable, mode, select and dwell. The slave side returns the registered decode.
interface decoder_n_scan_if #(
  parameter int N       = 2,
  parameter int DWELL_W = 8
);
  logic                 en_n;
  logic                 mode;
  logic [N-1:0]         sel;
  logic [DWELL_W-1:0]   dwell;
  logic [(1<<N)-1:0]    y;
  logic [N-1:0]         addr;
  logic                 step;
  logic                 wrap;

  modport master (output en_n, mode, sel, dwell, input  y, addr, step, wrap);
  modport slave  (input  en_n, mode, sel, dwell, output y, addr, step, wrap);
endinterface

// File: rtl/decoder_n_scan.sv
// N-to-2^N decoder with registered outputs.
// It either decodes sel directly or auto-scans a one-hot line, holding each index for dwell+1 enabled cycles.
module decoder_n_scan #(
  parameter int N          = 2,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DWELL_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  decoder_n_scan_if.slave    bus
);
  localparam int LINES = 1 << N;
  localparam logic [LINES-1:0] IDLE = ACTIVE_LOW ? {LINES{1'b1}} : {LINES{1'b0}};

  logic [N-1:0]       addr_q, addr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [LINES-1:0]   y_q, y_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;

  // Shared one-hot decoder: the next-state logic picks the index, and each line compares against it.
  logic [N-1:0]       dec_idx;
  logic               dec_en;
  logic [LINES-1:0]   line_on;

  for (genvar i = 0; i < LINES; i++) begin : g_line
    assign line_on[i] = (dec_idx == N'(i));
  end

  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    dec_idx = addr_q;
    dec_en  = 1'b0;
    if (!bus.en_n) begin
      dec_en = 1'b1;
      if (!bus.mode) begin
        addr_d  = bus.sel;
        cnt_d   = '0;
        dec_idx = bus.sel;
      end else if (cnt_q >= bus.dwell) begin
        // Dwell is compared live, so lowering it below cnt_q advances immediately.
        addr_d  = addr_q + 1'b1;
        cnt_d   = '0;
        dec_idx = addr_q + 1'b1;
        step_d  = 1'b1;
        wrap_d  = (addr_q == {N{1'b1}});
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end
    y_d = dec_en ? (line_on ^ IDLE) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      y_q    <= IDLE;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.addr = addr_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
endmodule
